// File: rtl/serial_addsub_seq_pkg.sv
// Shared arithmetic-slot definitions: sequencer state encoding and operation codes.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_seq_if.sv
// Request/result bundle of the bit-serial add/sub slot.
// Handshake: a request is taken on a rising edge where start=1, clr=0 and busy=0;
// op/a/b are sampled only on that edge, and done pulses for one cycle when result/cout/ovf are valid.
interface serial_addsub_seq_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic             clr;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, clr, op, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, clr, op, a, b,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_seq_full_adder.sv
// One-bit full adder cell, shared by every bit position of the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial adder/subtractor: one full_adder cell walked LSB-first, one bit per clock,
// with the carry held in a flop between bit positions.
module serial_addsub_seq
  import arith_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_addsub_seq_if.slave   bus,
  output state_t               dbg_state
);

  state_t             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   sa_q,     sa_d;
  logic [WIDTH-1:0]   sb_q,     sb_d;
  logic               carry_q,  carry_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q,   cout_d;
  logic               ovf_q,    ovf_d;

  logic fa_sum;
  logic fa_cout;

  full_adder u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    if (bus.clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            // SUB is a + ~b + 1: invert b once at load, carry-in of 1
            sa_d     = bus.a;
            sb_d     = (bus.op == OP_SUB) ? ~bus.b : bus.b;
            carry_d  = (bus.op == OP_SUB);
            cnt_d    = '0;
            result_d = '0;
            state_d  = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          result_d = {fa_sum, result_q[WIDTH-1:1]};
          carry_d  = fa_cout;
          sa_d     = sa_q >> 1;
          sb_d     = sb_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            // carry_q here is the carry into the MSB position
            cout_d  = fa_cout;
            ovf_d   = carry_q ^ fa_cout;
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign dbg_state  = state_q;

endmodule
